// File: rtl/layer_2_argmax_pkg.sv
// Shared definitions for the layer-2 argmax block.
//   - state encoding for the scan FSM
//   - class count and class-index width
//   - score width derivation from the layer-1/layer-2 operand widths
package layer_2_argmax_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = $clog2(NUM_CLASSES);

    localparam int DEF_LEAKY_LAYER_SIZE = 32;
    localparam int DEF_WEIGHT_SIZE      = 8;

    // A layer-2 score is a sum of leaky*weight products; one guard bit on
    // top of the operand widths is what the upstream matrix multiply emits.
    function automatic int score_width(input int leaky_w, input int weight_w);
        return leaky_w + weight_w + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/layer_2_argmax_signed_max_compare.sv
// Combinational signed compare-and-select for the argmax scan.
// Ports:
//   cand_val/cand_idx  candidate score and its class index
//   best_val/best_idx  running best score and its class index
//   new_val/new_idx    selected best after this comparison
//   take               1 when the candidate replaces the running best
// A strict greater-than keeps the lowest index on ties.
module signed_max_compare #(
    parameter int W     = 41,
    parameter int IDX_W = 4
) (
    input  logic [W-1:0]     cand_val,
    input  logic [IDX_W-1:0] cand_idx,
    input  logic [W-1:0]     best_val,
    input  logic [IDX_W-1:0] best_idx,
    output logic [W-1:0]     new_val,
    output logic [IDX_W-1:0] new_idx,
    output logic             take
);

    always_comb begin
        take    = $signed(cand_val) > $signed(best_val);
        new_val = take ? cand_val : best_val;
        new_idx = take ? cand_idx : best_idx;
    end

endmodule

// File: rtl/layer_2_argmax.sv
// Layer-2 argmax: captures the 10 class scores on a load pulse, scans them
// one comparison per cycle and reports the winning class and its score with
// a one-cycle done pulse, 10 cycles after the load edge.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   load                            one-cycle pulse, scores valid this cycle
//   layer_2_output_1..10            signed class scores, classes 0..9
//   busy                            high while scanning or reporting
//   done                            one-cycle result pulse
//   class_index, max_value          result, held until the next report
module layer_2_argmax
    import layer_2_argmax_pkg::*;
#(
    parameter int LEAKY_LAYER_SIZE = DEF_LEAKY_LAYER_SIZE,
    parameter int WEIGHT_SIZE      = DEF_WEIGHT_SIZE,
    parameter int SCORE_WIDTH      = score_width(LEAKY_LAYER_SIZE, WEIGHT_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_1,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_2,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_3,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_4,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_5,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_6,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_7,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_8,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_9,
    input  logic [SCORE_WIDTH-1:0] layer_2_output_10,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             class_index,
    output logic [SCORE_WIDTH-1:0] max_value
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [NUM_CLASSES-1:0][SCORE_WIDTH-1:0] scores_in;
    logic [NUM_CLASSES-1:0][SCORE_WIDTH-1:0] store_q, store_d;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SCORE_WIDTH-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IDX_W-1:0]       class_index_q, class_index_d;
    logic [SCORE_WIDTH-1:0] max_value_q, max_value_d;

    logic [SCORE_WIDTH-1:0] cand_val;
    logic [SCORE_WIDTH-1:0] cmp_val;
    logic [IDX_W-1:0]       cmp_idx;
    logic                   cmp_take;

    always_comb begin
        scores_in[0] = layer_2_output_1;
        scores_in[1] = layer_2_output_2;
        scores_in[2] = layer_2_output_3;
        scores_in[3] = layer_2_output_4;
        scores_in[4] = layer_2_output_5;
        scores_in[5] = layer_2_output_6;
        scores_in[6] = layer_2_output_7;
        scores_in[7] = layer_2_output_8;
        scores_in[8] = layer_2_output_9;
        scores_in[9] = layer_2_output_10;
    end

    // idx_q sits at NUM_CLASSES after a finished scan; guard the read so the
    // store is never indexed out of range.
    always_comb begin
        cand_val = '0;
        if (idx_q <= LAST_IDX) cand_val = store_q[idx_q];
    end

    signed_max_compare #(
        .W     (SCORE_WIDTH),
        .IDX_W (IDX_W)
    ) u_cmp (
        .cand_val (cand_val),
        .cand_idx (idx_q),
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .new_val  (cmp_val),
        .new_idx  (cmp_idx),
        .take     (cmp_take)
    );

    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        idx_d         = idx_q;
        best_val_d    = best_val_q;
        best_idx_d    = best_idx_q;
        class_index_d = class_index_q;
        max_value_d   = max_value_q;
        done_d        = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (cmp_take) begin
                    best_val_d = cmp_val;
                    best_idx_d = cmp_idx;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                class_index_d = best_idx_q;
                max_value_d   = best_val_q;
                done_d        = 1'b1;
                state_d       = ST_IDLE;
            end
            default: ;
        endcase

        // A load overrides the scan bookkeeping from any state, but the
        // result commit above survives so a load landing on REPORT still
        // delivers the previous answer.
        if (load) begin
            store_d    = scores_in;
            best_val_d = scores_in[0];
            best_idx_d = '0;
            idx_d      = IDX_W'(1);
            state_d    = ST_SCAN;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            store_q       <= '0;
            idx_q         <= '0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            class_index_q <= '0;
            max_value_q   <= '0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            idx_q         <= idx_d;
            best_val_q    <= best_val_d;
            best_idx_q    <= best_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            class_index_q <= class_index_d;
            max_value_q   <= max_value_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign class_index = 4'(class_index_q);
    assign max_value   = max_value_q;

endmodule
